// File: rtl/byte_data_memory.sv
// Byte-addressable 32-bit data memory with byte/half/word loads and stores,
// alignment and range checking, and an IDLE/ACCESS/RESP handshake.
module byte_data_memory #(
    parameter int unsigned MEMORY_DEPTH = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h1001_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic        Ready,
    output logic        Valid,
    output logic [31:0] ReadData,
    output logic        AlignErr,
    output logic        RangeErr
);

    localparam int          IDX_W = $clog2(MEMORY_DEPTH);
    localparam logic [32:0] SPAN  = 33'(MEMORY_DEPTH) << 2;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]       state;
    logic             accept;
    logic             isOp;
    logic             alignErrIn;
    logic             rangeErrIn;
    logic             errIn;
    logic [31:0]      offset;
    logic [IDX_W-1:0] idxIn;
    logic [3:0]       laneEn;
    logic [31:0]      laneData;

    logic [1:0]       rSize;
    logic             rUnsigned;
    logic [1:0]       rLane;
    logic [IDX_W-1:0] rIdx;
    logic             rAlignErr;
    logic             rRangeErr;
    logic             rLoad;
    logic [31:0]      dataReg;
    logic [31:0]      shifted;
    logic [31:0]      loadVal;

    logic [31:0] mem [MEMORY_DEPTH];

    // Request decode straight from the inputs; only meaningful at acceptance.
    always_comb begin
        offset     = Address - BASE_ADDR;
        idxIn      = offset[IDX_W+1:2];
        isOp       = MemRead | MemWrite;
        alignErrIn = isOp && ((Size == 2'b11) ||
                              (Size == 2'b01 && Address[0]) ||
                              (Size == 2'b10 && Address[1:0] != 2'b00));
        // Below-base addresses wrap to huge offsets and fail this compare too.
        rangeErrIn = isOp && ({1'b0, offset} >= SPAN);
        errIn      = alignErrIn | rangeErrIn;
        accept     = Req && (state == IDLE);
    end

    always_comb begin
        laneEn   = 4'b0000;
        laneData = WriteData;
        case (Size)
            2'b00: begin
                laneEn   = 4'b0001 << Address[1:0];
                laneData = {4{WriteData[7:0]}};
            end
            2'b01: begin
                laneEn   = Address[1] ? 4'b1100 : 4'b0011;
                laneData = {2{WriteData[15:0]}};
            end
            2'b10:   laneEn = 4'b1111;
            default: laneEn = 4'b0000;
        endcase
    end

    // NOTE: the array has no reset branch -- contents must survive reset and
    // a resettable array would not map onto RAM.
    always_ff @(posedge clk) begin
        if (accept && MemWrite && !errIn) begin
            for (int i = 0; i < 4; i++) begin
                if (laneEn[i]) mem[idxIn][8*i +: 8] <= laneData[8*i +: 8];
            end
        end
        if (state == ACCESS) dataReg <= mem[rIdx];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rSize     <= 2'b00;
            rUnsigned <= 1'b0;
            rLane     <= 2'b00;
            rIdx      <= '0;
            rAlignErr <= 1'b0;
            rRangeErr <= 1'b0;
            rLoad     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rSize     <= Size;
                        rUnsigned <= Unsigned;
                        rLane     <= Address[1:0];
                        rIdx      <= idxIn;
                        rAlignErr <= alignErrIn;
                        rRangeErr <= rangeErrIn;
                        rLoad     <= MemRead && !MemWrite && !errIn;
                        state     <= (MemRead && !MemWrite && !errIn) ? ACCESS : RESP;
                    end
                end
                ACCESS:  state <= RESP;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        shifted = dataReg >> {rLane, 3'b000};
        case (rSize)
            2'b00:   loadVal = rUnsigned ? {24'b0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   loadVal = rUnsigned ? {16'b0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
            default: loadVal = dataReg;
        endcase
    end

    assign Ready    = (state == IDLE);
    assign Valid    = (state == RESP);
    assign AlignErr = Valid & rAlignErr;
    assign RangeErr = Valid & rRangeErr;
    assign ReadData = (Valid && rLoad) ? loadVal : 32'h0;

endmodule

// File: tb/tb_byte_data_memory.sv
// Randomized scoreboard bench for byte_data_memory: a byte-array reference
// model predicts each response, a negedge monitor checks what the DUT returns.
module tb_byte_data_memory;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int unsigned NBYTE = 4 * DEPTH;

    logic        clk = 1'b0;
    logic        reset;
    logic        Req, MemWrite, MemRead, Unsigned;
    logic [1:0]  Size;
    logic [31:0] Address, WriteData;
    logic        Ready, Valid, AlignErr, RangeErr;
    logic [31:0] ReadData;

    byte_data_memory #(.MEMORY_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .Req(Req), .MemWrite(MemWrite), .MemRead(MemRead),
        .Size(Size), .Unsigned(Unsigned), .Address(Address), .WriteData(WriteData),
        .Ready(Ready), .Valid(Valid), .ReadData(ReadData), .AlignErr(AlignErr),
        .RangeErr(RangeErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        align;
        logic        range;
        int          edgesAfter;   // extra rising edges after acceptance before Valid
        int          accCycle;
    } exp_t;

    exp_t        sb[$];
    exp_t        monE;
    logic [7:0]  mdl [NBYTE];
    int          nChecks = 0;
    int          nFails  = 0;
    int          cycles  = 0;

    always @(posedge clk) cycles <= cycles + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference behaviour expressed over a flat byte array.
    function automatic exp_t predict(input bit w, input bit r, input logic [1:0] sz,
                                     input bit uns, input logic [31:0] addr,
                                     input logic [31:0] wd);
        exp_t        e;
        logic [31:0] o;
        int          nb;
        longint      v;
        e.data = 0; e.align = 0; e.range = 0; e.edgesAfter = 0;
        if (w || r) begin
            nb      = 1 << sz;
            o       = addr - BASE;
            e.align = (sz == 2'b11) || ((addr % nb) != 0);
            e.range = (o >= NBYTE);
            if (!e.align && !e.range) begin
                if (w) begin
                    for (int k = 0; k < nb; k++) mdl[int'(o) + k] = 8'((wd >> (8 * k)) & 32'hFF);
                end else begin
                    v = 0;
                    for (int k = nb - 1; k >= 0; k--) v = v * 256 + longint'(mdl[int'(o) + k]);
                    if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
                        v = v - (longint'(1) << (8 * nb));
                    e.data       = v[31:0];
                    e.edgesAfter = 1;
                end
            end
        end
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 right after the acceptance edge.
    task automatic issue(input string nm, input bit w, input bit r, input logic [1:0] sz,
                         input bit uns, input logic [31:0] addr, input logic [31:0] wd,
                         input bit hold = 0, input bit useExp = 0,
                         input logic [31:0] expData = 0);
        exp_t e;
        int   waitCnt = 0;
        Req = 1; MemWrite = w; MemRead = r; Size = sz; Unsigned = uns;
        Address = addr; WriteData = wd;
        while (!Ready && waitCnt < 20) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        if (!Ready) begin
            nChecks++; nFails++;
            $display("FAIL %s: Ready never rose, got 0 expected 1", nm);
            Req = 0;
            return;
        end
        e          = predict(w, r, sz, uns, addr, wd);
        e.name     = nm;
        e.accCycle = cycles + 1;
        if (useExp) e.data = expData;
        sb.push_back(e);
        @(posedge clk); #1;
        if (!hold) begin
            // Scrambled fields must not disturb the captured request.
            Req = 0; MemWrite = 1'($urandom); MemRead = 1'($urandom); Size = 2'($urandom);
            Unsigned = 1'($urandom); Address = $urandom; WriteData = $urandom;
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (Valid) begin
                if (sb.size() == 0) begin
                    nChecks++; nFails++;
                    $display("FAIL unexpected Valid: got 1 expected 0");
                end else begin
                    monE = sb.pop_front();
                    check({monE.name, " data"},  64'(ReadData), 64'(monE.data));
                    check({monE.name, " align"}, 64'(AlignErr), 64'(monE.align));
                    check({monE.name, " range"}, 64'(RangeErr), 64'(monE.range));
                    check({monE.name, " latency"}, 64'(cycles - monE.accCycle),
                          64'(monE.edgesAfter));
                end
            end else begin
                check("idle outputs", {31'b0, ReadData, AlignErr, RangeErr}, 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        int          kind;
        int          drain;

        reset = 1; Req = 0; MemWrite = 0; MemRead = 0; Size = 0; Unsigned = 0;
        Address = 0; WriteData = 0;
        repeat (2) @(negedge clk);
        check("reset Ready", 64'(Ready), 64'd1);
        check("reset Valid", 64'(Valid), 64'd0);
        check("reset outputs", {31'b0, ReadData, AlignErr, RangeErr}, 64'd0);
        @(posedge clk); #1;
        reset = 0;
        @(posedge clk); #1;

        for (int i = 0; i < DEPTH; i++) issue("init sw", 1, 0, 2'b10, 0, BASE + 4 * i, $urandom);

        issue("sw deadbeef", 1, 0, 2'b10, 0, BASE,     32'hDEAD_BEEF);
        issue("lw",          0, 1, 2'b10, 0, BASE,     0, 0, 1, 32'hDEAD_BEEF);
        issue("sb 80",       1, 0, 2'b00, 0, BASE + 1, 32'h1234_5680);
        issue("lb",          0, 1, 2'b00, 0, BASE + 1, 0, 0, 1, 32'hFFFF_FF80);
        issue("lbu",         0, 1, 2'b00, 1, BASE + 1, 0, 0, 1, 32'h0000_0080);
        issue("lw after sb", 0, 1, 2'b10, 0, BASE,     0, 0, 1, 32'hDEAD_80EF);
        issue("sh 8001",     1, 0, 2'b01, 0, BASE + 2, 32'hABCD_8001);
        issue("lh",          0, 1, 2'b01, 0, BASE + 2, 0, 0, 1, 32'hFFFF_8001);
        issue("lhu",         0, 1, 2'b01, 1, BASE + 2, 0, 0, 1, 32'h0000_8001);
        issue("lw after sh", 0, 1, 2'b10, 0, BASE,     0, 0, 1, 32'h8001_80EF);
        issue("lw misalign", 0, 1, 2'b10, 0, BASE + 2, 0);
        issue("sw past end", 1, 0, 2'b10, 0, BASE + NBYTE, 32'h5555_5555);
        issue("sw below",    1, 0, 2'b10, 0, BASE - 4, 32'h6666_6666);
        issue("size 11 oob", 0, 1, 2'b11, 0, BASE - 1, 0);
        issue("no-op req",   0, 0, 2'b10, 0, BASE, 32'hFFFF_FFFF);
        issue("lw word0",    0, 1, 2'b10, 0, BASE,     0, 0, 1, 32'h8001_80EF);

        // Reset while a load sits in ACCESS: response is dropped, data kept.
        issue("lw killed", 0, 1, 2'b10, 0, BASE, 0);
        reset = 1;
        #1;
        check("reset in ACCESS Ready", 64'(Ready), 64'd1);
        check("reset in ACCESS Valid", 64'(Valid), 64'd0);
        check("reset in ACCESS data",  64'(ReadData), 64'd0);
        void'(sb.pop_back());
        @(posedge clk); #1;
        reset = 0;
        repeat (4) @(posedge clk);
        #1;
        issue("lw after reset", 0, 1, 2'b10, 0, BASE, 0, 0, 1, 32'h8001_80EF);

        // Req held high throughout: each op must be accepted exactly once.
        for (int i = 0; i < 20; i++) begin
            a = BASE + 4 * $urandom_range(0, DEPTH - 1);
            issue("held sw", 1, 0, 2'b10, 0, a, $urandom, 1);
            issue("held lw", 0, 1, 2'b10, 0, a, 0, 1);
        end
        Req = 0;

        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 9);
            sz   = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            case ($urandom_range(0, 19))
                0:       a = BASE - 4 * $urandom_range(1, 4) + $urandom_range(0, 3);
                1:       a = BASE + NBYTE + $urandom_range(0, 255);
                default: a = BASE + $urandom_range(0, NBYTE - 1);
            endcase
            if (sz != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 1);
            if (kind < 4)
                issue("rnd store", 1, 1'($urandom), sz, 1'($urandom), a, $urandom, i[4]);
            else if (kind < 9)
                issue("rnd load", 0, 1, sz, 1'($urandom), a, $urandom, i[4]);
            else
                issue("rnd none", 0, 0, sz, 1'($urandom), a, $urandom, i[4]);
        end
        Req = 0;

        drain = 0;
        while (sb.size() > 0 && drain < 50) begin
            @(posedge clk);
            drain++;
        end
        repeat (3) @(posedge clk);
        check("responses outstanding", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/byte_data_memory.md
BYTE_DATA_MEMORY -- requirements
Module: byte_data_memory

Interface
REQ-001 Parameter MEMORY_DEPTH, default 1024, number of 32-bit words; SHALL be a power of two, minimum 4.
REQ-002 Parameter BASE_ADDR, default 32'h1001_0000, byte address of word 0; SHALL be word-aligned.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 Req  input  1  request strobe; accepted when Req and Ready are both 1 at a rising edge.
REQ-006 MemWrite  input  1  store request; takes priority over MemRead.
REQ-007 MemRead  input  1  load request.
REQ-008 Size  input  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-009 Unsigned  input  1  load extension: 1 zero-extend, 0 sign-extend.
REQ-010 Address  input  32  byte address.
REQ-011 WriteData  input  32  store data; byte/half taken from bits [7:0]/[15:0].
REQ-012 Ready  output  1  block idle and able to accept.
REQ-013 Valid  output  1  one-cycle completion pulse.
REQ-014 ReadData  output  32  load result; qualified by Valid.
REQ-015 AlignErr  output  1  misaligned or reserved-size request; qualified by Valid.
REQ-016 RangeErr  output  1  address outside [BASE_ADDR, BASE_ADDR+4*MEMORY_DEPTH); qualified by Valid.

Function
REQ-017 FSM states IDLE, ACCESS, RESP; Ready SHALL be 1 only in IDLE.
REQ-018 Request fields SHALL be captured into registers at acceptance; later input changes are ignored until the next acceptance.
REQ-019 AlignErr condition: Size=01 with Address[0]=1, Size=10 with Address[1:0]!=00, or Size=11.
REQ-020 RangeErr condition: (Address-BASE_ADDR) unsigned, 32-bit, >= 4*MEMORY_DEPTH; below-base addresses wrap to large offsets and SHALL flag.
REQ-021 Word index SHALL be (Address-BASE_ADDR)>>2; byte lane is Address[1:0], little-endian (lane 0 = bits [7:0]).
REQ-022 Error request: IDLE->RESP; no array write; Valid=1 with flag(s) set, ReadData=0; both flags may be set together.
REQ-023 Store (MemWrite=1, no error): enabled lanes written at the acceptance edge; IDLE->RESP; Valid next cycle, ReadData=0; unselected lanes unchanged.
REQ-024 Store lanes: byte writes lane Address[1:0]; half writes lanes {Address[1],0} and {Address[1],1}; word writes all four.
REQ-025 Load (MemRead=1, MemWrite=0, no error): IDLE->ACCESS (array read into data register) ->RESP; Valid two cycles after the acceptance edge.
REQ-026 Load result: selected byte/half shifted to bit 0, extended per Unsigned; word returned unmodified.
REQ-027 Req with neither MemRead nor MemWrite: IDLE->RESP; Valid with ReadData=0, flags 0.
REQ-028 RESP->IDLE unconditionally; Valid, AlignErr, RangeErr SHALL be 1 only in RESP; ReadData SHALL be 0 outside RESP.
REQ-029 A load following a store to the same word SHALL return the newly stored bytes.
REQ-030 Req while Ready=0 SHALL be ignored, not queued.

Reset
REQ-031 reset=1 SHALL force state IDLE immediately, Ready=1, Valid=0, ReadData=0, AlignErr=0, RangeErr=0.
REQ-032 Array contents SHALL NOT be cleared by reset; a store already written at its acceptance edge persists; an in-flight load is discarded with no Valid.

Verification
REQ-033 Store word 32'hDEADBEEF @BASE_ADDR, then lw @BASE_ADDR -> Valid 2 cycles after accept, ReadData=32'hDEADBEEF, flags 0.
REQ-034 Store byte 8'h80 @BASE_ADDR+1, then lb -> 32'hFFFFFF80; lbu -> 32'h00000080; lw -> 32'hDEAD80EF.
REQ-035 Store half 16'h8001 @BASE_ADDR+2 over 32'hDEAD80EF, then lh -> 32'hFFFF8001, lhu -> 32'h00008001, lw -> 32'h800180EF.
REQ-036 lw @BASE_ADDR+2 -> Valid next cycle, AlignErr=1, ReadData=0; sw @BASE_ADDR+4*MEMORY_DEPTH -> RangeErr=1, word 0 unchanged on readback.
REQ-037 Assert reset during ACCESS of a load -> Ready=1 and Valid=0 immediately, no Valid pulse follows; next lw returns previously stored data.
REQ-038 Req held high continuously with alternating sw/lw -> exactly one accept per FSM round (Ready gaps), no duplicated or lost accesses.
